piradip_spi_bit_engine: RTL and testbench

- SPI master serial engine that sits between the TX stream-to-bit shifter and the RX bit-to-stream shifter.
- Pulls MOSI bits from the TX shifter and generates SCLK/CS_N per CPOL/CPHA with a programmable divider.
- Samples MISO and pushes each bit into the RX shifter.
- At the end of each transfer, pulses `align` so both shifters flush or realign partial words.

---
 rtl/piradip_spi_bit_engine.sv | 184 ++++++++++++++++++
 tb/tb_piradip_spi_bit_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/piradip_spi_bit_engine.sv
// SPI master bit engine: pops MOSI bits from the TX shifter, drives SCLK/CS_N for any
// CPOL/CPHA, pushes sampled MISO bits to the RX shifter and pulses align at transfer end.
module piradip_spi_bit_engine #(
    parameter int DIV_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic                 cfg_cpol,
    input  logic                 cfg_cpha,
    input  logic [DIV_WIDTH-1:0] cfg_clk_div,
    input  logic [CNT_WIDTH-1:0] cfg_xfer_bits,
    input  logic                 tx_bit_valid,
    output logic                 tx_bit_ready,
    input  logic                 tx_bit_data,
    output logic                 rx_bit_valid,
    input  logic                 rx_bit_ready,
    output logic                 rx_bit_data,
    output logic                 align,
    output logic                 busy,
    output logic                 done,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 mosi,
    input  logic                 miso
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD   = 3'd1,
        ACTIVE = 3'd2,
        TRAIL  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t               state;
    logic                 cpol;
    logic                 cpha;
    logic                 lead_pend;
    logic [DIV_WIDTH-1:0] clk_div;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [CNT_WIDTH-1:0] xfer_bits;
    logic [CNT_WIDTH:0]   edge_cnt;

    logic                 tick;
    logic                 leading;
    logic                 final_edge;
    logic [CNT_WIDTH:0]   last_edge;
    logic                 launch_edge;
    logic                 sample_edge;
    logic                 launch_pt;
    logic                 sample_pt;
    logic                 stall;

    // edge_cnt holds toggles already made, so the pending edge is odd (leading) when it is even
    assign tick        = (div_cnt == clk_div);
    assign leading     = ~edge_cnt[0];
    assign last_edge   = {xfer_bits, 1'b0} - (CNT_WIDTH + 1)'(1);
    assign final_edge  = (edge_cnt == last_edge);
    assign launch_edge = cpha ? leading : (~leading & ~final_edge);
    assign sample_edge = cpha ? ~leading : leading;

    assign launch_pt = ((state == LEAD) && lead_pend) ||
                       ((state == ACTIVE) && tick && launch_edge);
    assign sample_pt = (state == ACTIVE) && tick && sample_edge;

    // Any stall freezes the divider, so no SCLK edge can slip past a handshake
    assign stall = (launch_pt && !tx_bit_valid) ||
                   (sample_pt && rx_bit_valid && !rx_bit_ready) ||
                   ((state == TRAIL) && rx_bit_valid && !rx_bit_ready);

    assign tx_bit_ready = rstn && launch_pt && tx_bit_valid;
    assign start_ready  = (state == IDLE);
    assign busy         = (state != IDLE);

    // Transfer sequencer, divider, SPI pins and RX holding register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            cpol         <= 1'b0;
            cpha         <= 1'b0;
            lead_pend    <= 1'b0;
            clk_div      <= '0;
            div_cnt      <= '0;
            xfer_bits    <= '0;
            edge_cnt     <= '0;
            sclk         <= 1'b0;
            cs_n         <= 1'b1;
            mosi         <= 1'b0;
            rx_bit_valid <= 1'b0;
            rx_bit_data  <= 1'b0;
            align        <= 1'b0;
            done         <= 1'b0;
        end else begin
            align <= 1'b0;
            done  <= 1'b0;
            if (rx_bit_valid && rx_bit_ready) begin
                rx_bit_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    sclk     <= cfg_cpol;
                    cs_n     <= 1'b1;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    if (start_valid) begin
                        cpol      <= cfg_cpol;
                        cpha      <= cfg_cpha;
                        clk_div   <= cfg_clk_div;
                        xfer_bits <= cfg_xfer_bits;
                        lead_pend <= ~cfg_cpha;
                        if (cfg_xfer_bits == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            align <= 1'b1;
                        end else begin
                            cs_n  <= 1'b0;
                            state <= LEAD;
                        end
                    end
                end
                LEAD: begin
                    if (!stall) begin
                        if (launch_pt) begin
                            mosi      <= tx_bit_data;
                            lead_pend <= 1'b0;
                        end
                        if (tick) begin
                            div_cnt <= '0;
                            state   <= ACTIVE;
                        end else begin
                            div_cnt <= div_cnt + DIV_WIDTH'(1);
                        end
                    end
                end
                ACTIVE: begin
                    if (!stall) begin
                        if (tick) begin
                            div_cnt  <= '0;
                            sclk     <= ~sclk;
                            edge_cnt <= edge_cnt + (CNT_WIDTH + 1)'(1);
                            if (launch_pt) begin
                                mosi <= tx_bit_data;
                            end
                            if (sample_pt) begin
                                rx_bit_data  <= miso;
                                rx_bit_valid <= 1'b1;
                            end
                            if (final_edge) begin
                                state <= TRAIL;
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_WIDTH'(1);
                        end
                    end
                end
                TRAIL: begin
                    sclk <= cpol;
                    if (!stall) begin
                        if (tick) begin
                            div_cnt <= '0;
                            cs_n    <= 1'b1;
                            done    <= 1'b1;
                            align   <= 1'b1;
                            state   <= DONE;
                        end else begin
                            div_cnt <= div_cnt + DIV_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    cs_n  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piradip_spi_bit_engine.sv
// Directed self-checking bench for piradip_spi_bit_engine with MISO looped back to MOSI.
module tb_piradip_spi_bit_engine;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_valid;
    logic        start_ready;
    logic        cfg_cpol;
    logic        cfg_cpha;
    logic [7:0]  cfg_clk_div;
    logic [15:0] cfg_xfer_bits;
    logic        tx_bit_valid;
    logic        tx_bit_ready;
    logic        tx_bit_data;
    logic        rx_bit_valid;
    logic        rx_bit_ready;
    logic        rx_bit_data;
    logic        align;
    logic        busy;
    logic        done;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;

    int checks = 0;
    int fails  = 0;

    int cs_low = 0, rises = 0, done_n = 0, align_n = 0, pops = 0, pushes = 0, mosi_bad = 0;
    logic        sclk_prev = 1'b0;
    logic        mosi_prev = 1'b0;
    logic [15:0] rx_sr = 16'h0000;
    logic [15:0] tx_pat;
    int          tx_base = 0;
    int b_cs, b_rise, b_done, b_align, b_pop, b_push, b_bad;

    piradip_spi_bit_engine #(.DIV_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .start_valid(start_valid), .start_ready(start_ready),
        .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_clk_div(cfg_clk_div),
        .cfg_xfer_bits(cfg_xfer_bits), .tx_bit_valid(tx_bit_valid),
        .tx_bit_ready(tx_bit_ready), .tx_bit_data(tx_bit_data),
        .rx_bit_valid(rx_bit_valid), .rx_bit_ready(rx_bit_ready),
        .rx_bit_data(rx_bit_data), .align(align), .busy(busy), .done(done),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    assign miso        = mosi;
    assign tx_bit_data = tx_pat[4'(pops - tx_base)];

    // Bus monitor: cumulative event counts, tests compare deltas
    always @(posedge clk) begin
        sclk_prev <= sclk;
        mosi_prev <= mosi;
        if (!cs_n) cs_low <= cs_low + 1;
        if (sclk && !sclk_prev) rises <= rises + 1;
        if (done) done_n <= done_n + 1;
        if (align) align_n <= align_n + 1;
        if (tx_bit_valid && tx_bit_ready) pops <= pops + 1;
        if (rx_bit_valid && rx_bit_ready) begin
            pushes <= pushes + 1;
            rx_sr  <= {rx_sr[14:0], rx_bit_data};
        end
        if (!cs_n && (mosi !== mosi_prev) && sclk) mosi_bad <= mosi_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic pol, input logic pha, input logic [7:0] div, input logic [15:0] n);
        cfg_cpol = pol; cfg_cpha = pha; cfg_clk_div = div; cfg_xfer_bits = n;
        start_valid = 1'b1;
        tx_base = pops;
        b_cs = cs_low; b_rise = rises; b_done = done_n; b_align = align_n;
        b_pop = pops; b_push = pushes; b_bad = mosi_bad;
        check("start_ready_idle", start_ready, 1);
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 600 && done !== 1'b1; i++) @(negedge clk);
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_align_with_done"}, align, 1);
        check({tag, "_cs_high_at_done"}, cs_n, 1);
    endtask

    task automatic after_xfer(input string tag, input int exp_cs, input int exp_rise,
                              input int n, input logic [15:0] mask, input logic [15:0] exp_rx);
        @(negedge clk);
        check({tag, "_cs_low_cycles"}, cs_low - b_cs, exp_cs);
        check({tag, "_sclk_pulses"}, rises - b_rise, exp_rise);
        check({tag, "_tx_pops"}, pops - b_pop, n);
        check({tag, "_rx_pushes"}, pushes - b_push, n);
        check({tag, "_done_pulses"}, done_n - b_done, 1);
        check({tag, "_align_pulses"}, align_n - b_align, 1);
        check({tag, "_rx_bits"}, rx_sr & mask, exp_rx);
        check({tag, "_mosi_edge"}, mosi_bad - b_bad, 0);
        check({tag, "_idle_again"}, {start_ready, busy}, 2'b10);
    endtask

    initial begin
        rstn = 1'b0; start_valid = 1'b0; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        cfg_clk_div = 8'd0; cfg_xfer_bits = 16'd0;
        tx_bit_valid = 1'b1; rx_bit_ready = 1'b1; tx_pat = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_rx", {rx_bit_valid, rx_bit_data}, 2'b00);
        check("rst_pulses", {tx_bit_ready, align, done, busy}, 4'b0000);
        check("rst_start_ready", start_ready, 1);
        rstn = 1'b1;
        @(negedge clk);

        // Mode 0, div 0, N=8, bits 1,0,1,0,0,1,0,1
        tx_pat = 16'h00A5;
        start(1'b0, 1'b0, 8'd0, 16'd8);
        wait_done("m0");
        after_xfer("m0", 18, 8, 8, 16'h00FF, 16'h00A5);

        // Mode 3, div 2, N=4, bits 1,1,0,0
        cfg_cpol = 1'b1;
        repeat (2) @(negedge clk);
        check("m3_sclk_idle_high", sclk, 1);
        tx_pat = 16'h0003;
        start(1'b1, 1'b1, 8'd2, 16'd4);
        check("m3_sclk_lead_high", sclk, 1);
        wait_done("m3");
        after_xfer("m3", 30, 4, 4, 16'h000F, 16'h000C);
        check("m3_sclk_back_high", sclk, 1);
        cfg_cpol = 1'b0;
        repeat (2) @(negedge clk);

        // TX underrun across the bit-3 launch point: 5 frozen cycles
        tx_pat = 16'h0036;
        start(1'b0, 1'b0, 8'd1, 16'd8);
        for (int i = 0; i < 200 && (pops - tx_base) != 3; i++) @(negedge clk);
        check("un_reach_bit3", pops - tx_base, 3);
        tx_bit_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("un_no_pop_while_invalid", pops - tx_base, 3);
        tx_bit_valid = 1'b1;
        wait_done("un");
        after_xfer("un", 41, 8, 8, 16'h00FF, 16'h006C);

        // RX backpressure: ready low 7 cycles while bit 2 is held
        tx_pat = 16'h00E4;
        start(1'b0, 1'b0, 8'd0, 16'd8);
        for (int i = 0; i < 200 && (pushes - b_push) != 2; i++) @(negedge clk);
        check("bp_reach_bit2", pushes - b_push, 2);
        rx_bit_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_valid_held", rx_bit_valid, 1);
        check("bp_data_bit2", rx_bit_data, 1);
        check("bp_no_push", pushes - b_push, 2);
        repeat (4) @(negedge clk);
        check("bp_data_stable", rx_bit_data, 1);
        rx_bit_ready = 1'b1;
        wait_done("bp");
        after_xfer("bp", 23, 8, 8, 16'h00FF, 16'h0027);

        // Zero-length transfer
        start(1'b0, 1'b0, 8'd0, 16'd0);
        check("z_done", {done, align}, 2'b11);
        check("z_cs_high", cs_n, 1);
        check("z_busy", {start_ready, busy}, 2'b01);
        @(negedge clk);
        check("z_pulse_one_cycle", {done, align}, 2'b00);
        check("z_ready_back", start_ready, 1);
        check("z_no_cs", cs_low - b_cs, 0);
        check("z_no_sclk", rises - b_rise, 0);
        check("z_no_pops", pops - b_pop, 0);

        // Reset mid-ACTIVE at bit 5, then a clean transfer
        tx_pat = 16'h00FF;
        start(1'b0, 1'b0, 8'd0, 16'd8);
        for (int i = 0; i < 200 && (pushes - b_push) != 5; i++) @(negedge clk);
        check("rs_reach_bit5", pushes - b_push, 5);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("rs_cs_n", cs_n, 1);
        check("rs_sclk", sclk, 0);
        check("rs_busy", {busy, start_ready}, 2'b01);
        check("rs_outs", {mosi, rx_bit_valid, rx_bit_data, tx_bit_ready}, 4'b0000);
        repeat (4) @(negedge clk);
        check("rs_no_done", done_n - b_done, 0);
        check("rs_no_align", align_n - b_align, 0);
        tx_pat = 16'h0059;
        start(1'b0, 1'b0, 8'd0, 16'd8);
        wait_done("rs2");
        after_xfer("rs2", 18, 8, 8, 16'h00FF, 16'h009A);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
